// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core.
// Covers what forwarding cannot: load-use, a branch in ID waiting on an operand,
// the multi-cycle EX multiply and cache freeze. Produces pipeline-register write
// enables, bubbles, the IF/ID flush, the multiplier handshake and two saturating
// performance counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | no multiply in flight; a multiply in EX is started here
//   MUL_BUSY | multiply in flight; cnt counts stall cycles left before done
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_RegSrc1_i,
   input  logic [4:0]       ID_RegSrc2_i,
   input  logic             ID_UseSrc1_i,
   input  logic             ID_UseSrc2_i,
   input  logic             ID_IsBranch_i,
   input  logic             ID_BranchTaken_i,
   input  logic             EX_RegWrite_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_RegDest_i,
   input  logic             EX_MulValid_i,
   input  logic             MEM_MemRead_i,
   input  logic [4:0]       MEM_RegDest_i,
   input  logic             ICache_stall_i,
   input  logic             DCache_stall_i,
   output logic             PC_Write_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Write_o,
   output logic             IDEX_Bubble_o,
   output logic             EXMEM_Write_o,
   output logic             EXMEM_Bubble_o,
   output logic             MEMWB_Write_o,
   output logic             Mul_Start_o,
   output logic             Mul_Done_o,
   output logic [CNT_W-1:0] Stall_Cycles_o,
   output logic [CNT_W-1:0] Flush_Count_o
);

   typedef enum logic {RUN, MUL_BUSY} state_t;

   // MUL_LAT-2 stall cycles follow the start cycle before the done cycle.
   localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT - 2);
   localparam bit         MUL_MULTI = (MUL_LAT > 1);

   state_t     state;
   logic [3:0] cnt;

   logic ex_match;
   logic mem_match;
   logic hz_load;
   logic hz_br;
   logic freeze;
   logic mul_stall;
   logic mul_start;
   logic mul_done;

   // A nonzero destination that matches a source the ID instruction really reads.
   function automatic logic dest_hits(input logic [4:0] dest,
                                      input logic [4:0] src1, input logic use1,
                                      input logic [4:0] src2, input logic use2);
      return (dest != 5'd0) &&
             ((use1 && (dest == src1)) || (use2 && (dest == src2)));
   endfunction

   // Hazard terms and multiplier handshake decode.
   always_comb begin
      ex_match  = dest_hits(EX_RegDest_i, ID_RegSrc1_i, ID_UseSrc1_i,
                            ID_RegSrc2_i, ID_UseSrc2_i);
      mem_match = dest_hits(MEM_RegDest_i, ID_RegSrc1_i, ID_UseSrc1_i,
                            ID_RegSrc2_i, ID_UseSrc2_i);
      hz_load   = EX_MemRead_i & ex_match;
      hz_br     = ID_IsBranch_i & ((EX_RegWrite_i & ex_match) |
                                   (MEM_MemRead_i & mem_match));
      freeze    = ICache_stall_i | DCache_stall_i;

      mul_start = 1'b0;
      mul_stall = 1'b0;
      mul_done  = 1'b0;
      if (!freeze) begin
         if (state == RUN) begin
            mul_start = EX_MulValid_i;
            mul_stall = EX_MulValid_i & MUL_MULTI;
            mul_done  = EX_MulValid_i & !MUL_MULTI;
         end else begin
            mul_stall = (cnt != 4'd0);
            mul_done  = (cnt == 4'd0);
         end
      end
   end

   // Pipeline control outputs in priority order; everything is quiet in reset.
   always_comb begin
      PC_Write_o     = 1'b0;
      IFID_Write_o   = 1'b0;
      IFID_Flush_o   = 1'b0;
      IDEX_Write_o   = 1'b0;
      IDEX_Bubble_o  = 1'b0;
      EXMEM_Write_o  = 1'b0;
      EXMEM_Bubble_o = 1'b0;
      MEMWB_Write_o  = 1'b0;
      Mul_Start_o    = 1'b0;
      Mul_Done_o     = 1'b0;
      if (rst_n && !freeze) begin
         Mul_Start_o   = mul_start;
         Mul_Done_o    = mul_done;
         EXMEM_Write_o = 1'b1;
         MEMWB_Write_o = 1'b1;
         if (mul_stall) begin
            EXMEM_Bubble_o = 1'b1;
         end else if (hz_load || hz_br) begin
            IDEX_Write_o  = 1'b1;
            IDEX_Bubble_o = 1'b1;
         end else begin
            PC_Write_o   = 1'b1;
            IFID_Write_o = 1'b1;
            IDEX_Write_o = 1'b1;
            IFID_Flush_o = ID_BranchTaken_i;
         end
      end
   end

   // Multiplier sequencing; freeze holds both state and count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else if (!freeze) begin
         case (state)
            RUN: begin
               if (EX_MulValid_i && MUL_MULTI) begin
                  state <= MUL_BUSY;
                  cnt   <= CNT_INIT;
               end
            end
            MUL_BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state <= RUN;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Stall_Cycles_o <= '0;
         Flush_Count_o  <= '0;
      end else begin
         if (!PC_Write_o && !(&Stall_Cycles_o)) begin
            Stall_Cycles_o <= Stall_Cycles_o + CNT_W'(1);
         end
         if (IFID_Flush_o && !(&Flush_Count_o)) begin
            Flush_Count_o <= Flush_Count_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model kept in this file.
module tb_hazard_stall_ctrl;

   localparam int MUL_LAT = 4;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_src1, id_src2, ex_dest, mem_dest;
   logic id_use1, id_use2, id_br, id_taken;
   logic ex_rw, ex_mr, ex_mul, mem_mr, ic_st, dc_st;
   logic pc_w, ifid_w, ifid_fl, idex_w, idex_b, exmem_w, exmem_b, memwb_w;
   logic mul_start, mul_done;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles of the current multiply already spent in
   // EX (unfrozen), or -1 when no multiply is in flight.
   int mul_elapsed = -1;
   int m_stalls = 0;
   int m_flushes = 0;
   logic e_pc, e_ifid, e_fl, e_idex, e_idexb, e_exmem, e_exmemb, e_memwb, e_start, e_done;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_RegSrc1_i(id_src1), .ID_RegSrc2_i(id_src2),
      .ID_UseSrc1_i(id_use1), .ID_UseSrc2_i(id_use2),
      .ID_IsBranch_i(id_br), .ID_BranchTaken_i(id_taken),
      .EX_RegWrite_i(ex_rw), .EX_MemRead_i(ex_mr), .EX_RegDest_i(ex_dest),
      .EX_MulValid_i(ex_mul), .MEM_MemRead_i(mem_mr), .MEM_RegDest_i(mem_dest),
      .ICache_stall_i(ic_st), .DCache_stall_i(dc_st),
      .PC_Write_o(pc_w), .IFID_Write_o(ifid_w), .IFID_Flush_o(ifid_fl),
      .IDEX_Write_o(idex_w), .IDEX_Bubble_o(idex_b),
      .EXMEM_Write_o(exmem_w), .EXMEM_Bubble_o(exmem_b), .MEMWB_Write_o(memwb_w),
      .Mul_Start_o(mul_start), .Mul_Done_o(mul_done),
      .Stall_Cycles_o(stall_cnt), .Flush_Count_o(flush_cnt)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit reads(input logic [4:0] d);
      return (d != 0) && ((id_use1 && d == id_src1) || (id_use2 && d == id_src2));
   endfunction

   // Expected outputs for the current inputs, from the priority rules.
   task automatic model_eval();
      bit frz, stall_mul, hz;
      frz = ic_st || dc_st;
      hz  = (ex_mr && reads(ex_dest)) ||
            (id_br && ((ex_rw && reads(ex_dest)) || (mem_mr && reads(mem_dest))));
      e_start = 0; e_done = 0; stall_mul = 0;
      if (!frz) begin
         if (mul_elapsed < 0 && ex_mul) begin
            e_start = 1;
            if (MUL_LAT == 1) e_done = 1; else stall_mul = 1;
         end else if (mul_elapsed >= 0) begin
            if (mul_elapsed == MUL_LAT - 1) e_done = 1; else stall_mul = 1;
         end
      end
      {e_pc, e_ifid, e_fl, e_idex, e_idexb, e_exmem, e_exmemb, e_memwb} = '0;
      if (!rst_n) begin
         e_start = 0; e_done = 0;
      end else if (frz) begin
      end else if (stall_mul) begin
         e_exmemb = 1; e_exmem = 1; e_memwb = 1;
      end else if (hz) begin
         e_idexb = 1; e_idex = 1; e_exmem = 1; e_memwb = 1;
      end else begin
         e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1; e_memwb = 1; e_fl = id_taken;
      end
   endtask

   task automatic model_clock();
      if (!rst_n) return;
      if (!e_pc) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      if (e_fl) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      if (!(ic_st || dc_st)) begin
         if (mul_elapsed < 0) begin
            if (ex_mul && MUL_LAT > 1) mul_elapsed = 1;
         end else if (mul_elapsed == MUL_LAT - 1) begin
            mul_elapsed = -1;
         end else begin
            mul_elapsed++;
         end
      end
   endtask

   task automatic check_all();
      model_eval();
      check("pc_write", pc_w, e_pc);
      check("ifid_write", ifid_w, e_ifid);
      check("ifid_flush", ifid_fl, e_fl);
      check("idex_write", idex_w, e_idex);
      check("idex_bubble", idex_b, e_idexb);
      check("exmem_write", exmem_w, e_exmem);
      check("exmem_bubble", exmem_b, e_exmemb);
      check("memwb_write", memwb_w, e_memwb);
      check("mul_start", mul_start, e_start);
      check("mul_done", mul_done, e_done);
      check("stall_cycles", stall_cnt, m_stalls);
      check("flush_count", flush_cnt, m_flushes);
   endtask

   // Inputs already applied; check mid-cycle, then let the model follow the edge.
   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      {id_src1, id_src2, ex_dest, mem_dest} = '0;
      {id_use1, id_use2, id_br, id_taken, ex_rw, ex_mr, ex_mul, mem_mr, ic_st, dc_st} = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      mul_elapsed = -1; m_stalls = 0; m_flushes = 0;
      #1;
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1;
      @(negedge clk);
      do_reset();

      // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
      ex_mr = 1; ex_rw = 1; ex_dest = 5; id_src1 = 5; id_use1 = 1; id_src2 = 1; id_use2 = 1;
      step();
      check("lu_stall_pc", pc_w, 0);
      ex_mr = 0; ex_rw = 0; ex_dest = 0; mem_mr = 1; mem_dest = 5;
      step();
      check("lu_resume_pc", pc_w, 1);
      check("lu_stall_cnt", stall_cnt, 1);

      // Load then beq x5,x0 taken: two stall cycles, then flush.
      idle_inputs(); do_reset();
      ex_mr = 1; ex_rw = 1; ex_dest = 5; id_src1 = 5; id_use1 = 1; id_use2 = 1;
      id_br = 1; id_taken = 1;
      step();
      check("br_stall1", ifid_fl, 0);
      ex_mr = 0; ex_rw = 0; ex_dest = 0; mem_mr = 1; mem_dest = 5;
      step();
      check("br_stall2", pc_w, 0);
      mem_mr = 0; mem_dest = 0;
      step();
      check("br_flush", ifid_fl, 1);
      idle_inputs();
      step();
      check("br_flush_cnt", flush_cnt, 1);
      check("br_stall_total", stall_cnt, 2);

      // Multiply with MUL_LAT=4: done on the fourth cycle.
      do_reset();
      ex_mul = 1;
      step(); step(); step();
      check("mul_done_t3", mul_done, 1);
      step();
      ex_mul = 0;
      check("mul_stall_cnt", stall_cnt, 3);

      // Same multiply with a 2-cycle D-cache freeze at t+1.
      do_reset();
      ex_mul = 1;
      step();
      dc_st = 1; step(); step();
      dc_st = 0; step(); step();
      check("mulfz_done_t5", mul_done, 1);
      step();
      ex_mul = 0;

      // x0 destination never creates a hazard.
      idle_inputs(); do_reset();
      ex_mr = 1; id_use1 = 1;
      step();
      check("x0_no_stall", pc_w, 1);

      // Reset in the middle of a multiply abandons it.
      idle_inputs();
      ex_mul = 1; step(); ex_mul = 0; step();
      do_reset();
      step();
      check("rst_mid_mul_done", mul_done, 0);
      check("rst_mid_mul_cnt", stall_cnt, 0);

      // Saturation of the stall counter.
      ic_st = 1;
      for (int i = 0; i < 20; i++) step();
      ic_st = 0;
      step();
      check("stall_sat", stall_cnt, CMAX);

      // Random traffic with occasional resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end
         id_src1  = 5'($urandom_range(0, 3));
         id_src2  = 5'($urandom_range(0, 3));
         ex_dest  = 5'($urandom_range(0, 3));
         mem_dest = 5'($urandom_range(0, 3));
         id_use1  = 1'($urandom_range(0, 1));
         id_use2  = 1'($urandom_range(0, 1));
         id_br    = ($urandom_range(0, 3) == 0);
         id_taken = 1'($urandom_range(0, 1));
         ex_rw    = 1'($urandom_range(0, 1));
         ex_mr    = ($urandom_range(0, 3) == 0);
         mem_mr   = ($urandom_range(0, 3) == 0);
         ex_mul   = ($urandom_range(0, 4) == 0);
         ic_st    = ($urandom_range(0, 9) == 0);
         dc_st    = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
